// File: rtl/simple_mmap_axil_regs.sv
// rtl/simple_mmap_axil_regs.sv - AXI4-Lite register file (CTRL1, STATUS, SCRATCH, COUNT) for Simple_MMap
// Define SIMPLE_MMAP_WSTRB_EN to honour byte strobes on RW registers; otherwise writes are full-word.
module simple_mmap_axil_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] CTRL1_RESET        = 32'h0000_0000
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [31:0]                       ctrl1,
  input  logic [31:0]                       status_in
);

  localparam logic [1:0] IDX_CTRL1   = 2'd0;
  localparam logic [1:0] IDX_STATUS  = 2'd1;
  localparam logic [1:0] IDX_SCRATCH = 2'd2;
  localparam logic [1:0] IDX_COUNT   = 2'd3;

  logic        awready_q, awready_d;
  logic        wready_q,  wready_d;
  logic        aw_held_q, aw_held_d;
  logic [1:0]  aw_idx_q,  aw_idx_d;
  logic        w_held_q,  w_held_d;
  logic [31:0] w_data_q,  w_data_d;
  logic [3:0]  w_strb_q,  w_strb_d;
  logic        bvalid_q,  bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q,  rvalid_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [31:0] ctrl1_q,   ctrl1_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] count_q,   count_d;

  logic        aw_hs, w_hs, ar_hs, wr_go;
  logic [1:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] wr_mask;
  logic        unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                       s00_axi_araddr[1:0], wr_strb};

  always_comb begin
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    ctrl1_d   = ctrl1_q;
    scratch_d = scratch_q;
    count_d   = count_q + 32'd1;

    aw_hs = s00_axi_awvalid & awready_q;
    w_hs  = s00_axi_wvalid & wready_q;
    ar_hs = s00_axi_arvalid & arready_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s00_axi_awaddr[3:2];
      awready_d = 1'b0;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s00_axi_wdata;
      w_strb_d = s00_axi_wstrb;
      wready_d = 1'b0;
    end

    // A captured half comes from its holding flop, a half arriving this cycle comes straight off the bus.
    wr_go   = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    wr_idx  = aw_held_q ? aw_idx_q : s00_axi_awaddr[3:2];
    wr_data = w_held_q ? w_data_q : s00_axi_wdata;
    wr_strb = w_held_q ? w_strb_q : s00_axi_wstrb;
`ifdef SIMPLE_MMAP_WSTRB_EN
    wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
`else
    wr_mask = 32'hFFFF_FFFF;
`endif

    if (wr_go) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (wr_idx)
        IDX_CTRL1:   ctrl1_d   = (ctrl1_q & ~wr_mask) | (wr_data & wr_mask);
        IDX_SCRATCH: scratch_d = (scratch_q & ~wr_mask) | (wr_data & wr_mask);
        default:     ;
      endcase
    end

    // Readies stay low through the response so the next write cannot overlap it.
    if (bvalid_q & s00_axi_bready) begin
      bvalid_d  = 1'b0;
      awready_d = 1'b1;
      wready_d  = 1'b1;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      case (s00_axi_araddr[3:2])
        IDX_CTRL1:   rdata_d = ctrl1_q;
        IDX_STATUS:  rdata_d = status_in;
        IDX_SCRATCH: rdata_d = scratch_q;
        IDX_COUNT:   rdata_d = count_q;
        default:     rdata_d = 32'h0;
      endcase
    end else if (rvalid_q & s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      aw_held_q <= 1'b0;
      aw_idx_q  <= 2'd0;
      w_held_q  <= 1'b0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      ctrl1_q   <= CTRL1_RESET;
      scratch_q <= 32'h0;
      count_q   <= 32'h0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl1_q   <= ctrl1_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign ctrl1           = ctrl1_q;

endmodule
